// File: rtl/ring_slide_injector_pkg.sv
// Shared types for the ring slide injector and the cluster ring router.
//   elen_t         : one vector element word
//   id_cluster_t   : cluster ID
//   num_cluster_t  : log2 of the active cluster count
//   ring_cmd_t     : slide/reduction command {stride, dir_up, nwords}
//   remote_data_t  : ring payload {data, src_cluster, dst_cluster}
//   ring_dst_cluster() : destination cluster arithmetic (modulo cluster count)
package ring_slide_injector_pkg;

  localparam int unsigned ELEN         = 64;
  localparam int unsigned IdWidth      = 4;
  localparam int unsigned RingCntWidth = 16;

  typedef logic [ELEN-1:0]    elen_t;
  typedef logic [IdWidth-1:0] id_cluster_t;
  typedef logic [2:0]         num_cluster_t;

  typedef struct packed {
    id_cluster_t             stride;
    logic                    dir_up;
    logic [RingCntWidth-1:0] nwords;
  } ring_cmd_t;

  typedef struct packed {
    elen_t       data;
    id_cluster_t src_cluster;
    id_cluster_t dst_cluster;
  } remote_data_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } inj_state_e;

  // Low log2n bits set. Computed one bit wider so log2n == IdWidth
  // yields an all-ones mask instead of zero.
  function automatic id_cluster_t cluster_mask(input num_cluster_t log2n);
    logic [IdWidth:0] m;
    m = ((IdWidth+1)'(1) << log2n) - (IdWidth+1)'(1);
    return m[IdWidth-1:0];
  endfunction

  // Arithmetic wraps in id_cluster_t width, then the mask reduces it
  // modulo the active cluster count.
  function automatic id_cluster_t ring_dst_cluster(input id_cluster_t  id,
                                                   input id_cluster_t  stride,
                                                   input logic         dir_up,
                                                   input num_cluster_t log2n);
    id_cluster_t sum;
    sum = dir_up ? id + stride : id - stride;
    return sum & cluster_mask(log2n);
  endfunction

endpackage

// File: rtl/ring_slide_injector_if.sv
// Handshake bundle of the ring slide injector.
//   cmd/cmd_valid/cmd_ready    : command channel (injector is sink)
//   data/data_valid/data_ready : word stream from the slide unit
//   ring/ring_valid/ring_ready : tagged words toward the router
//   loc/loc_valid/loc_ready    : local-bypass words
//   done, busy                 : status
// slave = injector side, master = environment side.
interface ring_slide_injector_if;
  import ring_slide_injector_pkg::*;

  ring_cmd_t    cmd;
  logic         cmd_valid;
  logic         cmd_ready;
  elen_t        data;
  logic         data_valid;
  logic         data_ready;
  remote_data_t ring;
  logic         ring_valid;
  logic         ring_ready;
  elen_t        loc;
  logic         loc_valid;
  logic         loc_ready;
  logic         done;
  logic         busy;

  modport slave (
    input  cmd, cmd_valid, data, data_valid, ring_ready, loc_ready,
    output cmd_ready, data_ready, ring, ring_valid, loc, loc_valid, done, busy
  );

  modport master (
    output cmd, cmd_valid, data, data_valid, ring_ready, loc_ready,
    input  cmd_ready, data_ready, ring, ring_valid, loc, loc_valid, done, busy
  );

endinterface

// File: rtl/ring_slide_injector_outreg.sv
// One-entry output register with valid/ready handshake, steered to either
// the ring or the local-bypass port.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   in_valid/in_ready  : load side; in_ready also true when the held word
//                        leaves in the same cycle (full throughput)
//   in_data, in_local  : word and its steering flag
//   out_data           : held word
//   ring_valid/ready   : ring-side handshake
//   loc_valid/ready    : local-side handshake
//   out_fire           : held word accepted this cycle
module ring_inj_outreg
  import ring_slide_injector_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  remote_data_t in_data,
  input  logic         in_local,
  output remote_data_t out_data,
  output logic         ring_valid,
  input  logic         ring_ready,
  output logic         loc_valid,
  input  logic         loc_ready,
  output logic         out_fire
);

  logic         full;
  logic         is_local;
  remote_data_t q;
  logic         sel_ready;

  assign sel_ready  = is_local ? loc_ready : ring_ready;
  assign out_fire   = full & sel_ready;
  assign in_ready   = ~full | sel_ready;
  assign ring_valid = full & ~is_local;
  assign loc_valid  = full & is_local;
  assign out_data   = q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full     <= 1'b0;
      is_local <= 1'b0;
      q        <= '0;
    end else if (in_valid & in_ready) begin
      full     <= 1'b1;
      is_local <= in_local;
      q        <= in_data;
    end else if (out_fire) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/ring_slide_injector.sv
// Injection stage upstream of the cluster ring router's SLDU port.
// Takes one command, then nwords ELEN words; tags each with src/dst
// cluster and emits it on the ring, or on the local-bypass port when the
// destination is this cluster.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   cluster_id_i    : this cluster's ID (sampled at command accept)
//   num_clusters_i  : log2 active cluster count (sampled at command accept)
//   bus (slave)     : cmd / data / ring / loc handshakes, done, busy
//   stall_cnt_o, word_cnt_o : saturating ring stall / ring word counters,
//                     present only when RING_INJ_PERF_EN is defined
module ring_slide_injector
  import ring_slide_injector_pkg::*;
#(
  parameter int unsigned CntWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  id_cluster_t           cluster_id_i,
  input  num_cluster_t          num_clusters_i,
  ring_slide_injector_if.slave  bus
`ifdef RING_INJ_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           word_cnt_o
`endif
);

  localparam int unsigned DataWidth = $bits(elen_t);

  inj_state_e           state;
  logic [CntWidth-1:0]  cnt;
  id_cluster_t          src_q, dst_q;
  logic                 local_q;
  logic                 done_q, busy_q, cmd_ready_q;

  logic                 cmd_fire, word_fire, last_word;
  id_cluster_t          cmd_dst;
  logic                 cmd_local;
  logic [DataWidth-1:0] word_d;

  remote_data_t         oreg_in, oreg_q;
  logic                 oreg_in_ready, oreg_out_fire;

  assign cmd_fire  = bus.cmd_valid & cmd_ready_q;
  assign cmd_dst   = ring_dst_cluster(cluster_id_i, bus.cmd.stride,
                                      bus.cmd.dir_up, num_clusters_i);
  // Compare against the in-range ID so that stride == 0 mod N is always
  // local, even if cluster_id_i carries bits above the active range.
  assign cmd_local = (cmd_dst == (cluster_id_i & cluster_mask(num_clusters_i)));

  assign bus.data_ready = (state == ST_RUN) & oreg_in_ready;
  assign word_fire      = bus.data_valid & bus.data_ready;
  assign last_word      = (cnt == CntWidth'(1));

  assign word_d  = bus.data;
  assign oreg_in = '{data: word_d, src_cluster: src_q, dst_cluster: dst_q};

  ring_inj_outreg u_outreg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid   (word_fire),
    .in_ready   (oreg_in_ready),
    .in_data    (oreg_in),
    .in_local   (local_q),
    .out_data   (oreg_q),
    .ring_valid (bus.ring_valid),
    .ring_ready (bus.ring_ready),
    .loc_valid  (bus.loc_valid),
    .loc_ready  (bus.loc_ready),
    .out_fire   (oreg_out_fire)
  );

  assign bus.ring      = oreg_q;
  assign bus.loc       = oreg_q.data;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      local_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (bus.cmd.nwords == '0) begin
              // Empty command: acknowledge immediately, no data phase.
              done_q <= 1'b1;
            end else begin
              cnt         <= CntWidth'(bus.cmd.nwords);
              src_q       <= cluster_id_i;
              dst_q       <= cmd_dst;
              local_q     <= cmd_local;
              state       <= ST_RUN;
              busy_q      <= 1'b1;
              cmd_ready_q <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (word_fire) begin
            cnt <= cnt - CntWidth'(1);
            if (last_word) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Register is always full on entry; finish once it drains.
          if (oreg_out_fire) begin
            done_q      <= 1'b1;
            state       <= ST_IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef RING_INJ_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      word_cnt_o  <= '0;
    end else begin
      if (bus.ring_valid & ~bus.ring_ready & (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (bus.ring_valid & bus.ring_ready & (word_cnt_o != '1))
        word_cnt_o <= word_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ring_slide_injector.sv
module tb_ring_slide_injector;
  import ring_slide_injector_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  id_cluster_t  cluster_id;
  num_cluster_t num_clusters;
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  ring_slide_injector_if bus();

`ifdef RING_INJ_PERF_EN
  logic [31:0] stall_cnt, word_cnt;
`endif

  ring_slide_injector dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cluster_id_i   (cluster_id),
    .num_clusters_i (num_clusters),
    .bus            (bus)
`ifdef RING_INJ_PERF_EN
    ,
    .stall_cnt_o    (stall_cnt),
    .word_cnt_o     (word_cnt)
`endif
  );

  typedef struct {
    id_cluster_t  id;
    num_cluster_t l2;
    id_cluster_t  stride;
    logic         up;
    int           n;
    logic [63:0]  base;
    int           rmode;    // 0: ready always high, 1: ready 1-0-0-1
    id_cluster_t  exp_dst;
    logic         exp_loc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input id_cluster_t id, input num_cluster_t l2,
                          input id_cluster_t stride, input logic up, input int n);
    cluster_id     = id;
    num_clusters   = l2;
    bus.cmd        = '{stride: stride, dir_up: up, nwords: 16'(n)};
    bus.cmd_valid  = 1'b1;
    #1;
    chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    cycle();
    bus.cmd_valid  = 1'b0;
    // Mid-command changes must be ignored.
    cluster_id     = ~id;
    num_clusters   = ~l2;
    chk("busy_after_cmd", 64'(bus.busy), 64'(n != 0));
    chk("cmd_ready_after_cmd", 64'(bus.cmd_ready), 64'(n == 0));
  endtask

  task automatic run_stream(input int n, input logic [63:0] base, input id_cluster_t src,
                            input id_cluster_t dst, input logic exp_loc, input int rmode);
    int          sent = 0, got = 0, cyc = 0;
    logic        last_fired = 1'b0, done_seen = 1'b0, stalled = 1'b0;
    logic        rdy, ov, infire;
    logic [63:0] held;
    logic [63:0] od;
    while (!done_seen && cyc < 200) begin
      rdy = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      bus.ring_ready = rdy;
      bus.loc_ready  = rdy;
      bus.data_valid = (sent < n);
      bus.data       = base + 64'(sent);
      #1;
      chk("done_timing", 64'(bus.done), 64'(last_fired));
      if (last_fired) done_seen = 1'b1;
      if (exp_loc) chk("ring_valid_quiet", 64'(bus.ring_valid), 64'd0);
      else         chk("loc_valid_quiet", 64'(bus.loc_valid), 64'd0);
      ov = exp_loc ? bus.loc_valid : bus.ring_valid;
      od = exp_loc ? bus.loc : bus.ring.data;
      if (stalled) begin
        chk("hold_valid", 64'(ov), 64'd1);
        chk("hold_data", od, held);
      end
      if (ov && !rdy) chk("data_ready_full", 64'(bus.data_ready), 64'd0);
      if (rmode == 0 && sent < n) chk("full_rate", 64'(bus.data_ready), 64'd1);
      last_fired = 1'b0;
      if (ov && rdy) begin
        chk("out_data", od, base + 64'(got));
        if (!exp_loc) begin
          chk("src_cluster", 64'(bus.ring.src_cluster), 64'(src));
          chk("dst_cluster", 64'(bus.ring.dst_cluster), 64'(dst));
        end
        if (rmode == 0) chk("latency", 64'(cyc), 64'(got + 1));
        got++;
        last_fired = (got == n);
      end
      stalled = ov && !rdy;
      held    = od;
      infire  = bus.data_valid & bus.data_ready;
      cycle();
      if (infire) sent++;
      cyc++;
    end
    bus.data_valid = 1'b0;
    chk("words_out", 64'(got), 64'(n));
    chk("done_seen", 64'(done_seen), 64'd1);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    cycle();
    chk("done_one_cycle", 64'(bus.done), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'd1,  3'd2, 4'd1, 1'b1, 4, 64'hA,  0, 4'd2,  1'b0};
    vecs[1] = '{4'd0,  3'd2, 4'd1, 1'b0, 3, 64'h10, 0, 4'd3,  1'b0};
    vecs[2] = '{4'd2,  3'd2, 4'd5, 1'b1, 3, 64'h20, 0, 4'd3,  1'b0};
    vecs[3] = '{4'd2,  3'd1, 4'd2, 1'b1, 3, 64'h30, 0, 4'd0,  1'b1};
    vecs[4] = '{4'd3,  3'd3, 4'd8, 1'b0, 3, 64'h40, 0, 4'd3,  1'b1};
    vecs[5] = '{4'd7,  3'd4, 4'd9, 1'b0, 3, 64'h50, 0, 4'd14, 1'b0};
    vecs[6] = '{4'd15, 3'd4, 4'd1, 1'b1, 3, 64'h60, 0, 4'd0,  1'b0};
    vecs[7] = '{4'd1,  3'd2, 4'd2, 1'b1, 5, 64'h70, 1, 4'd3,  1'b0};
    vecs[8] = '{4'd2,  3'd1, 4'd2, 1'b1, 4, 64'h80, 1, 4'd0,  1'b1};
    vecs[9] = '{4'd0,  3'd0, 4'd3, 1'b1, 2, 64'h90, 0, 4'd0,  1'b1};

    rst            = 1'b1;
    cluster_id     = '0;
    num_clusters   = '0;
    bus.cmd        = '0;
    bus.cmd_valid  = 1'b0;
    bus.data       = '0;
    bus.data_valid = 1'b0;
    bus.ring_ready = 1'b1;
    bus.loc_ready  = 1'b1;
    cycle();
    cycle();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_data_ready", 64'(bus.data_ready), 64'd0);
    chk("rst_ring_valid", 64'(bus.ring_valid), 64'd0);
    chk("rst_loc_valid", 64'(bus.loc_valid), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    cycle();

    foreach (vecs[i]) begin
      send_cmd(vecs[i].id, vecs[i].l2, vecs[i].stride, vecs[i].up, vecs[i].n);
      run_stream(vecs[i].n, vecs[i].base, vecs[i].id, vecs[i].exp_dst,
                 vecs[i].exp_loc, vecs[i].rmode);
    end

    // Empty command: single done pulse, never busy, no output.
    send_cmd(4'd1, 3'd2, 4'd1, 1'b1, 0);
    chk("n0_done", 64'(bus.done), 64'd1);
    chk("n0_ring_valid", 64'(bus.ring_valid), 64'd0);
    chk("n0_loc_valid", 64'(bus.loc_valid), 64'd0);
    cycle();
    chk("n0_done_once", 64'(bus.done), 64'd0);
    chk("n0_busy", 64'(bus.busy), 64'd0);

    // Reset after 2 of 6 words.
    bus.ring_ready = 1'b1;
    bus.loc_ready  = 1'b1;
    send_cmd(4'd1, 3'd2, 4'd1, 1'b1, 6);
    bus.data_valid = 1'b1;
    bus.data       = 64'h100;
    cycle();
    bus.data       = 64'h101;
    cycle();
    chk("mid_ring_valid", 64'(bus.ring_valid), 64'd1);
    rst = 1'b1;
    cycle();
    chk("mr_ring_valid", 64'(bus.ring_valid), 64'd0);
    chk("mr_loc_valid", 64'(bus.loc_valid), 64'd0);
    chk("mr_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("mr_done", 64'(bus.done), 64'd0);
    chk("mr_busy", 64'(bus.busy), 64'd0);
    chk("mr_data_ready", 64'(bus.data_ready), 64'd0);
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    cycle();
    chk("mr_no_done", 64'(bus.done), 64'd0);
    chk("mr_still_empty", 64'(bus.ring_valid), 64'd0);

    send_cmd(4'd1, 3'd2, 4'd1, 1'b1, 3);
    run_stream(3, 64'h200, 4'd1, 4'd2, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
